wb_slave_timeout: RTL

Wishbone watchdog stage placed on one slave port of the interconnect, between the interconnect's slave-side `wb_if.master` and the peripheral. It passes classic (non-pipelined) Wishbone cycles through with zero added latency and counts wait cycles. If the peripheral fails to answer within `TIMEOUT` cycles, it aborts the peripheral cycle and returns `ERR` to the interconnect. An unmapped or hung peripheral therefore can never lock a master.

---
 rtl/wb_slave_timeout_pkg.sv | 8 +
 rtl/wb_if.sv | 27 ++
 rtl/wb_sat_counter.sv | 25 ++
 rtl/wb_slave_timeout.sv | 118 +++++++++++
 4 files changed

// File: rtl/wb_slave_timeout_pkg.sv
// rtl/wb_slave_timeout_pkg.sv - shared types and constants for the Wishbone slave watchdog
package wb_slave_timeout_pkg;

  typedef enum logic [1:0] {TO_IDLE, TO_ACTIVE, TO_ABORT} to_state_e;

  localparam int TO_STATUS_CNT_W = 16;

endpackage

// File: rtl/wb_if.sv
// rtl/wb_if.sv - classic Wishbone bus bundle with master and slave views
interface wb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   ADR;
  logic [2:0]      CTI;
  logic [1:0]      BTE;
  logic [DW-1:0]   DAT_W;
  logic [DW-1:0]   DAT_R;
  logic [DW/8-1:0] SEL;
  logic            WE;
  logic            CYC;
  logic            STB;
  logic            ACK;
  logic            ERR;

  modport master (
    output ADR, CTI, BTE, DAT_W, SEL, WE, CYC, STB,
    input  DAT_R, ACK, ERR
  );

  modport slave (
    input  ADR, CTI, BTE, DAT_W, SEL, WE, CYC, STB,
    output DAT_R, ACK, ERR
  );
endinterface

// File: rtl/wb_sat_counter.sv
// rtl/wb_sat_counter.sv - saturating up-counter with synchronous clear
module wb_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  // Increment applies after the clear, so a coincident clear and event yields 1.
  always_comb begin
    cnt_d = clr_i ? '0 : cnt_q;
    if (inc_i && !(&cnt_d)) cnt_d = cnt_d + W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/wb_slave_timeout.sv
// rtl/wb_slave_timeout.sv - zero-latency Wishbone pass-through that aborts unanswered cycles
// Optional abort status ports are built when WB_SLAVE_TIMEOUT_STATUS_EN is defined.
module wb_slave_timeout
  import wb_slave_timeout_pkg::*;
#(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int TIMEOUT       = 256
) (
  input  logic clk,
  input  logic rstn,
  wb_if.slave  m,
  wb_if.master s,
  output logic timeout_o
`ifdef WB_SLAVE_TIMEOUT_STATUS_EN
  ,
  output logic [WB_ADDR_WIDTH-1:0]   to_addr_o,
  output logic                       to_we_o,
  output logic [TO_STATUS_CNT_W-1:0] to_count_o,
  input  logic                       to_clr_i
`endif
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int SEL_W = WB_DATA_WIDTH / 8;

  to_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req, rsp, abort, pass;

  assign req   = m.CYC & m.STB;
  assign rsp   = s.ACK | s.ERR;
  assign abort = (state_q == TO_ABORT);
  assign pass  = rstn & ~abort;

  // The cycle in which req is first seen only arms the counter; counting starts in ACTIVE.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      TO_IDLE: begin
        if (req) state_d = TO_ACTIVE;
      end
      TO_ACTIVE: begin
        if (!req) begin
          state_d = TO_IDLE;
        end else if (!rsp) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(TIMEOUT - 1)) state_d = TO_ABORT;
        end
      end
      TO_ABORT: state_d = TO_IDLE;
      default:  state_d = TO_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= TO_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign s.ADR   = WB_ADDR_WIDTH'(m.ADR);
  assign s.CTI   = m.CTI;
  assign s.BTE   = m.BTE;
  assign s.DAT_W = WB_DATA_WIDTH'(m.DAT_W);
  assign s.SEL   = SEL_W'(m.SEL);
  assign s.WE    = m.WE;
  assign s.CYC   = pass & m.CYC;
  assign s.STB   = pass & m.STB;

  // A late peripheral answer during the abort cycle is dropped entirely.
  assign m.DAT_R = pass ? WB_DATA_WIDTH'(s.DAT_R) : '0;
  assign m.ACK   = pass & s.ACK;
  assign m.ERR   = rstn & (abort | s.ERR);
  assign timeout_o = abort;

`ifdef WB_SLAVE_TIMEOUT_STATUS_EN
  logic                     abort_enter;
  logic [WB_ADDR_WIDTH-1:0] to_addr_q, to_addr_d;
  logic                     to_we_q, to_we_d;

  assign abort_enter = (state_q == TO_ACTIVE) && (state_d == TO_ABORT);

  always_comb begin
    to_addr_d = to_clr_i ? '0 : to_addr_q;
    to_we_d   = to_clr_i ? 1'b0 : to_we_q;
    if (abort_enter) begin
      to_addr_d = WB_ADDR_WIDTH'(m.ADR);
      to_we_d   = m.WE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_addr_q <= '0;
      to_we_q   <= 1'b0;
    end else begin
      to_addr_q <= to_addr_d;
      to_we_q   <= to_we_d;
    end
  end

  wb_sat_counter #(.W(TO_STATUS_CNT_W)) u_to_count (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (to_clr_i),
    .inc_i (abort_enter),
    .cnt_o (to_count_o)
  );

  assign to_addr_o = to_addr_q;
  assign to_we_o   = to_we_q;
`endif
endmodule
